// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared definitions for the USB receive front end.
//   - unstuff_state_t : unstuffer state (DATA, SKIP)
//   - USB_STUFF_RUN   : decoded 1s after which a stuffed 0 is inserted
//   - USB_J_LEVEL     : D+ level of the idle (J) line state
package usb_rx_pkg;

  localparam int unsigned USB_STUFF_RUN = 6;
  localparam logic        USB_J_LEVEL   = 1'b1;

  typedef enum logic [0:0] {
    DATA = 1'b0,
    SKIP = 1'b1
  } unstuff_state_t;

endpackage

// File: rtl/nrzi_bit_decoder.sv
// nrzi_bit_decoder: registers the D+ line level and the level seen at the last
// bit strobe, and produces the combinational NRZI-decoded bit.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   d_plus        - synchronised D+ level, sampled every clock
//   shift_enable  - bit-centre strobe
//   eop           - end of packet; re-arms the previous level to IDLE_LEVEL
//   b_c           - decoded bit for the current strobe (combinational)
module nrzi_bit_decoder #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic shift_enable,
  input  logic eop,
  output logic b_c
);

  logic line_q, line_d;
  logic prev_q, prev_d;

  // NRZI: no transition between strobes is a 1, a transition is a 0.
  assign b_c = ~(line_q ^ prev_q);

  // Next line / previous-level values; EOP returns the reference to idle (J).
  always_comb begin
    line_d = d_plus;
    prev_d = prev_q;
    if (shift_enable) begin
      if (eop) begin
        prev_d = IDLE_LEVEL;
      end else begin
        prev_d = line_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      line_q <= line_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/usb_nrzi_unstuff.sv
// usb_nrzi_unstuff: USB receive front end combining NRZI decode, bit
// unstuffing and stuff-error detection in one registered stage.
// Build option: define NRZI_STUFF_ERR_EN to generate stuff_err; otherwise
// stuff_err is held at 0 and every stuffed bit is dropped silently.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   d_plus        - synchronised D+ level
//   shift_enable  - one-cycle bit-centre strobe
//   eop           - end of packet level, acted on at strobes
//   d_orig        - decoded data bit (registered)
//   d_valid       - one-cycle pulse: d_orig holds a real data bit
//   stuff_err     - one-cycle pulse: the stuffed-bit position held a 1
//   ones_cnt      - current run of consecutive decoded 1s (debug)
module usb_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_RUN  = USB_STUFF_RUN,
  parameter logic        IDLE_LEVEL = USB_J_LEVEL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             d_plus,
  input  logic                             shift_enable,
  input  logic                             eop,
  output logic                             d_orig,
  output logic                             d_valid,
  output logic                             stuff_err,
  output logic [$clog2(STUFF_RUN+1)-1:0]   ones_cnt
);

  localparam int unsigned CNT_W = $clog2(STUFF_RUN + 1);

  logic             b_c;
  unstuff_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_orig_q, d_orig_d;
  logic             d_valid_q, d_valid_d;
  logic             stuff_err_q, stuff_err_d;

  nrzi_bit_decoder #(
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_dec (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .shift_enable (shift_enable),
    .eop          (eop),
    .b_c          (b_c)
  );

  // Unstuffing FSM: DATA passes bits through, SKIP consumes the stuffed bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_orig_d    = d_orig_q;
    d_valid_d   = 1'b0;
    stuff_err_d = 1'b0;
    if (shift_enable) begin
      if (eop) begin
        // EOP overrides any pending stuffed bit.
        state_d = DATA;
        cnt_d   = '0;
      end else if (state_q == DATA) begin
        d_orig_d  = b_c;
        d_valid_d = 1'b1;
        if (b_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
        if (cnt_d == CNT_W'(STUFF_RUN)) begin
          state_d = SKIP;
        end
      end else begin
        state_d = DATA;
`ifdef NRZI_STUFF_ERR_EN
        // A 1 in the stuffed slot is flagged and starts a new run of 1s.
        if (b_c) begin
          stuff_err_d = 1'b1;
          cnt_d       = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
`else
        cnt_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DATA;
      cnt_q       <= '0;
      d_orig_q    <= 1'b1;
      d_valid_q   <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_orig_q    <= d_orig_d;
      d_valid_q   <= d_valid_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign d_orig    = d_orig_q;
  assign d_valid   = d_valid_q;
  assign stuff_err = stuff_err_q;
  assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_usb_nrzi_unstuff.sv
// tb_usb_nrzi_unstuff: random and directed packets are bit-stuffed and NRZI
// encoded by the bench; a scoreboard monitor compares each strobe's outputs.
module tb_usb_nrzi_unstuff;

  localparam int unsigned RUN = 6;
  localparam int unsigned CW  = $clog2(RUN + 1);
`ifdef NRZI_STUFF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          d_plus;
  logic          shift_enable;
  logic          eop;
  logic          d_orig;
  logic          d_valid;
  logic          stuff_err;
  logic [CW-1:0] ones_cnt;

  always #5 clk = ~clk;

  usb_nrzi_unstuff #(
    .STUFF_RUN  (RUN),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .shift_enable (shift_enable),
    .eop          (eop),
    .d_orig       (d_orig),
    .d_valid      (d_valid),
    .stuff_err    (stuff_err),
    .ones_cnt     (ones_cnt)
  );

  typedef struct {
    bit          valid;
    bit          dbit;
    bit          err;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe taken outside reset must match the next expectation;
  // any other cycle must show no pulses.
  initial begin : monitor
    bit   strobe;
    exp_t e;
    forever begin
      @(posedge clk);
      strobe = (shift_enable === 1'b1) && (rst === 1'b0);
      @(negedge clk);
      if (strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_underflow: strobe with no expectation (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("d_valid", 32'(d_valid), 32'(e.valid));
          chk("stuff_err", 32'(stuff_err), 32'(e.err));
          chk("d_orig", 32'(d_orig), 32'(e.dbit));
          chk("ones_cnt", 32'(ones_cnt), e.cnt);
        end
      end else begin
        chk("idle_pulses", {30'd0, d_valid, stuff_err}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Line driver: a level is placed one cycle before the strobe that samples it.
  bit pend_se  = 1'b0;
  bit pend_eop = 1'b0;
  int gap_mode = -1;

  task automatic cycle(input logic dp, input logic se, input logic e);
    @(negedge clk);
    d_plus       = dp;
    shift_enable = se;
    eop          = e;
  endtask

  function automatic int unsigned get_gap();
    if (gap_mode >= 0) return int'(gap_mode);
    if ($urandom_range(0, 2) == 0) return 0;
    return $urandom_range(1, 7);
  endfunction

  task automatic send(input logic lvl, input bit e);
    int unsigned g;
    g = get_gap();
    cycle(lvl, pend_se, pend_eop);
    repeat (g) cycle(lvl, 1'b0, 1'b0);
    pend_se  = 1'b1;
    pend_eop = e;
  endtask

  task automatic flush();
    cycle(d_plus, pend_se, pend_eop);
    pend_se  = 1'b0;
    pend_eop = 1'b0;
    cycle(d_plus, 1'b0, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    flush();
    repeat (n) cycle(1'b1, 1'b0, 1'b0);
  endtask

  // Transmit-side model: stuffing and NRZI encoding of a bit stream.
  logic        g_level = 1'b1;
  int unsigned g_run   = 0;
  bit          g_last  = 1'b1;

  task automatic emit_data(input bit d);
    if (!d) g_level = ~g_level;
    g_run  = d ? g_run + 1 : 0;
    g_last = d;
    exp_q.push_back('{1'b1, d, 1'b0, g_run});
    send(g_level, 1'b0);
  endtask

  task automatic emit_stuff(input bit s);
    bit e;
    if (!s) g_level = ~g_level;
    e     = s && ERR_EN;
    g_run = e ? 1 : 0;
    exp_q.push_back('{1'b0, g_last, e, g_run});
    send(g_level, 1'b0);
  endtask

  task automatic emit_payload(input bit d, input bit inject);
    emit_data(d);
    if (g_run == RUN) emit_stuff(inject);
  endtask

  task automatic emit_eop();
    exp_q.push_back('{1'b0, g_last, 1'b0, 0});
    send(1'b0, 1'b1);
    g_level = 1'b1;
    g_run   = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_d_orig"}, 32'(d_orig), 32'd1);
    chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_stuff_err"}, 32'(stuff_err), 32'd0);
    chk({tag, "_ones_cnt"}, 32'(ones_cnt), 32'd0);
  endtask

  task automatic do_reset(input bit with_strobe);
    flush();
    repeat (2) cycle(d_plus, 1'b0, 1'b0);
    @(negedge clk);
    rst          = 1'b1;
    d_plus       = 1'b1;
    shift_enable = with_strobe;
    eop          = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    shift_enable = 1'b0;
    check_reset_values(with_strobe ? "rst_strobe" : "rst");
    g_level = 1'b1;
    g_run   = 0;
    g_last  = 1'b1;
  endtask

  initial begin : stim
    int unsigned len;
    rst          = 1'b1;
    d_plus       = 1'b1;
    shift_enable = 1'b0;
    eop          = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;

    // Idle J line with strobes every 8 clocks decodes as 1s.
    gap_mode = 7;
    repeat (4) emit_payload(1'b1, 1'b0);
    gap_mode = -1;
    // Two more 1s reach the run limit; a stuffed 0 follows.
    repeat (2) emit_payload(1'b1, 1'b0);
    emit_payload(1'b0, 1'b0);
    emit_payload(1'b1, 1'b0);
    emit_eop();
    idle(3);

    // Six 1s then a 1 in the stuffed slot.
    repeat (6) emit_payload(1'b1, 1'b1);
    emit_payload(1'b1, 1'b0);
    emit_payload(1'b0, 1'b0);
    emit_eop();
    idle(2);

    // EOP lands on the stuffed-bit strobe.
    repeat (6) emit_data(1'b1);
    emit_eop();
    idle(2);
    // First K of the next packet decodes to 0.
    emit_payload(1'b0, 1'b0);
    emit_payload(1'b1, 1'b0);
    emit_eop();
    idle(2);

    // Reset after four 1s, with a strobe on the reset cycle.
    repeat (4) emit_payload(1'b1, 1'b0);
    do_reset(1'b1);
    repeat (6) emit_payload(1'b1, 1'b0);
    emit_payload(1'b0, 1'b0);
    emit_eop();
    idle(2);
    repeat (3) emit_payload(1'b1, 1'b0);
    do_reset(1'b0);

    // Random packets, biased towards 1s to exercise stuffing.
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(8, 48);
      for (int i = 0; i < int'(len); i++) begin
        emit_payload($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      end
      emit_eop();
      idle($urandom_range(0, 3));
    end

    flush();
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
